// File: rtl/imem_arb_if.sv
// Fetch-port, loader-port and SRAM-side signals of the instruction-memory arbiter.
interface imem_arb_if;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    // Fetch (IF stage) port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          if_stall;

    // Loader port
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;
    logic [DW-1:0] ld_rdata;

    // SRAM port
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_valid, if_rdata, if_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_valid, if_rdata, if_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/imem_arb.sv
// imem_arb: shares one single-port instruction SRAM between the fetch stage and a loader.
// One access at a time: grant -> WAIT_CYC cycles of chip select -> one response cycle.
module imem_arb #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic      clk,
    input  logic      rst,
    imem_arb_if.slave bus
);
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner_ld;
    logic          last_gnt_ld;
    logic          drop;
    logic          we_q;
    logic          resp_fetch;
    logic          resp_ld;
    logic          cs_q;
    logic          mem_we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ld_rdata_q;

    logic arb_c;
    logic fetch_req_c;
    logic ld_req_c;
    logic gnt_fetch_c;
    logic gnt_ld_c;
    logic if_valid_c;
    logic ld_rd_c;

    // Arbitration: the requester being answered this cycle is not a new request,
    // except a dropped fetch whose requester has already moved on to a new address.
    always_comb begin
        arb_c       = (state == IDLE) || (state == RESP);
        fetch_req_c = bus.if_req && !bus.if_flush && !(resp_fetch && !drop);
        ld_req_c    = bus.ld_req && !resp_ld;
        gnt_fetch_c = arb_c && fetch_req_c && (!ld_req_c || last_gnt_ld);
        gnt_ld_c    = arb_c && ld_req_c && (!fetch_req_c || !last_gnt_ld);
        if_valid_c  = resp_fetch && !drop && !bus.if_flush;
        ld_rd_c     = resp_ld && !we_q;
    end

    // Response data is forwarded straight from the SRAM in the response cycle, held otherwise.
    assign bus.if_valid  = if_valid_c;
    assign bus.if_rdata  = if_valid_c ? bus.mem_rdata : if_rdata_q;
    assign bus.if_stall  = rst && bus.if_req && !if_valid_c && !bus.if_flush;
    assign bus.ld_ack    = resp_ld;
    assign bus.ld_rdata  = ld_rd_c ? bus.mem_rdata : ld_rdata_q;
    assign bus.mem_cs    = cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);

    // Access FSM with its latched request and registered SRAM controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_ld    <= 1'b0;
            last_gnt_ld <= 1'b1;
            drop        <= 1'b0;
            we_q        <= 1'b0;
            resp_fetch  <= 1'b0;
            resp_ld     <= 1'b0;
            cs_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    resp_fetch <= 1'b0;
                    resp_ld    <= 1'b0;
                    if (gnt_fetch_c || gnt_ld_c) begin
                        state       <= ACC;
                        owner_ld    <= gnt_ld_c;
                        last_gnt_ld <= gnt_ld_c;
                        drop        <= 1'b0;
                        cnt         <= CNT_LOAD;
                        addr_q      <= gnt_ld_c ? bus.ld_addr : bus.if_addr;
                        we_q        <= gnt_ld_c && bus.ld_we;
                        cs_q        <= 1'b1;
                        mem_we_q    <= gnt_ld_c && bus.ld_we;
                        if (gnt_ld_c) begin
                            wdata_q <= bus.ld_wdata;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC: begin
                    if (!owner_ld && bus.if_flush) begin
                        drop <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state      <= RESP;
                        cs_q       <= 1'b0;
                        mem_we_q   <= 1'b0;
                        resp_fetch <= !owner_ld;
                        resp_ld    <= owner_ld;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Hold the last delivered read data for each port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (if_valid_c) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (ld_rd_c) begin
                ld_rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_imem_arb;
    localparam int unsigned W = 3;

    logic clk = 1'b0;
    logic rst;

    imem_arb_if bus ();

    imem_arb #(.WAIT_CYC(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int phase  = 0;
    int last_phase = -1;
    int pcyc   = 0;
    int unsigned cyc = 0;

    // Model: the access in flight is described by its grant cycle g and its latched request.
    bit          act;
    int unsigned g;
    bit          own_ld;
    bit          m_we;
    bit          m_drop;
    bit          last_ld;
    logic [13:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] h_if;
    logic [31:0] h_ld;

    bit          in_acc;
    bit          in_resp;
    bit          fr;
    bit          lr;
    bit          pick_ld;
    bit          e_cs, e_we, e_ifv, e_lda, e_stall, e_busy;
    logic [13:0] e_addr;
    logic [31:0] e_wdata, e_ifd, e_ldd;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d phase %0d)", name, a, e, cyc, phase);
        end
    endtask

    // Compare process: evaluate the model for this cycle, check the DUT, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (phase != last_phase) begin
                pcyc = 0;
                last_phase = phase;
            end else begin
                pcyc = pcyc + 1;
            end
            in_acc  = 1'b0;
            in_resp = 1'b0;
            if (!rst) begin
                act = 0; own_ld = 0; m_we = 0; m_drop = 0; last_ld = 1;
                m_addr = '0; m_wdata = '0; h_if = '0; h_ld = '0;
                e_cs = 0; e_we = 0; e_ifv = 0; e_lda = 0; e_stall = 0; e_busy = 0;
                e_addr = '0; e_wdata = '0; e_ifd = '0; e_ldd = '0;
            end else begin
                in_acc  = act && (cyc > g) && (cyc <= g + W);
                in_resp = act && (cyc == g + W + 1);
                e_cs    = in_acc;
                e_we    = in_acc && m_we;
                e_addr  = m_addr;
                e_wdata = m_wdata;
                e_ifv   = in_resp && !own_ld && !m_drop && !bus.if_flush;
                e_ifd   = e_ifv ? bus.mem_rdata : h_if;
                e_lda   = in_resp && own_ld;
                e_ldd   = (e_lda && !m_we) ? bus.mem_rdata : h_ld;
                e_stall = bus.if_req && !e_ifv && !bus.if_flush;
                e_busy  = act;
            end

            chk("mem_cs",    32'(bus.mem_cs),    32'(e_cs));
            chk("mem_we",    32'(bus.mem_we),    32'(e_we));
            chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            chk("mem_wdata", bus.mem_wdata,      e_wdata);
            chk("if_valid",  32'(bus.if_valid),  32'(e_ifv));
            chk("if_rdata",  bus.if_rdata,       e_ifd);
            chk("if_stall",  32'(bus.if_stall),  32'(e_stall));
            chk("ld_ack",    32'(bus.ld_ack),    32'(e_lda));
            chk("ld_rdata",  bus.ld_rdata,       e_ldd);
            chk("busy",      32'(bus.busy),      32'(e_busy));

            // Hand-computed expectations for the directed scenarios (W = 3).
            case (phase)
                1: begin
                    if (pcyc == 0) chk("p1_stall", 32'(bus.if_stall), 32'd1);
                    if (pcyc == 1) chk("p1_cs", 32'(bus.mem_cs), 32'd1);
                    if (pcyc == 1) chk("p1_addr", 32'(bus.mem_addr), 32'h0004);
                    if (pcyc == 3) chk("p1_cs_last", 32'(bus.mem_cs), 32'd1);
                    if (pcyc == 4) chk("p1_cs_off", 32'(bus.mem_cs), 32'd0);
                    if (pcyc == 4) chk("p1_valid", 32'(bus.if_valid), 32'd1);
                    if (pcyc == 4) chk("p1_rdata", bus.if_rdata, 32'h0000_0013);
                    if (pcyc == 5) chk("p1_idle", 32'(bus.busy), 32'd0);
                end
                2: begin
                    if (pcyc == 1) chk("p2_we", 32'(bus.mem_we), 32'd1);
                    if (pcyc == 1) chk("p2_addr", 32'(bus.mem_addr), 32'h0010);
                    if (pcyc == 1) chk("p2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
                    if (pcyc == 3) chk("p2_we_last", 32'(bus.mem_we), 32'd1);
                    if (pcyc == 4) chk("p2_cs_off", 32'(bus.mem_cs), 32'd0);
                    if (pcyc == 4) chk("p2_ack", 32'(bus.ld_ack), 32'd1);
                    if (pcyc == 4) chk("p2_ld_rdata_hold", bus.ld_rdata, 32'h0);
                    if (pcyc == 4) chk("p2_no_ifv", 32'(bus.if_valid), 32'd0);
                    if (pcyc == 5) chk("p2_ack_once", 32'(bus.ld_ack), 32'd0);
                end
                3: begin
                    if (pcyc == 1) chk("p3_addr", 32'(bus.mem_addr), 32'h0008);
                    if (pcyc == 2) chk("p3_stall_flush", 32'(bus.if_stall), 32'd0);
                    if (pcyc == 4) chk("p3_dropped", 32'(bus.if_valid), 32'd0);
                    if (pcyc == 4) chk("p3_rdata_hold", bus.if_rdata, 32'h0000_0013);
                    if (pcyc == 5) chk("p3_new_cs", 32'(bus.mem_cs), 32'd1);
                    if (pcyc == 5) chk("p3_new_addr", 32'(bus.mem_addr), 32'h0020);
                    if (pcyc == 8) chk("p3_new_valid", 32'(bus.if_valid), 32'd1);
                    if (pcyc == 8) chk("p3_new_rdata", bus.if_rdata, 32'hCAFE_0020);
                end
                4: begin
                    if (pcyc == 1) chk("p4_cs", 32'(bus.mem_cs), 32'd1);
                    if (pcyc == 2) chk("p4_rst_cs", 32'(bus.mem_cs), 32'd0);
                    if (pcyc == 2) chk("p4_rst_busy", 32'(bus.busy), 32'd0);
                    if (pcyc == 2) chk("p4_rst_addr", 32'(bus.mem_addr), 32'h0);
                    if (pcyc == 3) chk("p4_rel_idle", 32'(bus.busy), 32'd0);
                    if (pcyc == 4) chk("p4_re_addr", 32'(bus.mem_addr), 32'h0030);
                    if (pcyc == 7) chk("p4_ack", 32'(bus.ld_ack), 32'd1);
                    if (pcyc == 7) chk("p4_rdata", bus.ld_rdata, 32'h1234_5678);
                end
                5: begin
                    if (pcyc == 5) chk("p5_fetch1", 32'(bus.if_valid), 32'd1);
                    if (pcyc == 5) chk("p5_no_ack1", 32'(bus.ld_ack), 32'd0);
                    if (pcyc == 9) chk("p5_load1", 32'(bus.ld_ack), 32'd1);
                    if (pcyc == 9) chk("p5_no_ifv", 32'(bus.if_valid), 32'd0);
                    if (pcyc == 13) chk("p5_fetch2", 32'(bus.if_valid), 32'd1);
                end
                default: begin
                end
            endcase

            if (rst) begin
                if (e_ifv) h_if = bus.mem_rdata;
                if (e_lda && !m_we) h_ld = bus.mem_rdata;
                if (in_acc && !own_ld && bus.if_flush) m_drop = 1;
                if (!act || in_resp) begin
                    fr = bus.if_req && !bus.if_flush && !(in_resp && !own_ld && !m_drop);
                    lr = bus.ld_req && !(in_resp && own_ld);
                    if (fr || lr) begin
                        pick_ld = lr && (!fr || !last_ld);
                        act     = 1;
                        g       = cyc;
                        own_ld  = pick_ld;
                        last_ld = pick_ld;
                        m_drop  = 0;
                        m_addr  = pick_ld ? bus.ld_addr : bus.if_addr;
                        m_we    = pick_ld && bus.ld_we;
                        if (pick_ld) m_wdata = bus.ld_wdata;
                    end else begin
                        act = 0;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random requester behaviour that honours the hold-until-done protocol of both ports.
    task automatic drive(input int pct, input int fl_div);
        bus.if_flush = 1'b0;
        if (fl_div != 0 && $urandom_range(fl_div - 1) == 0) bus.if_flush = 1'b1;
        if (!bus.if_req || e_ifv || bus.if_flush) begin
            bus.if_req  = (int'($urandom_range(99)) < pct);
            bus.if_addr = 14'($urandom);
        end
        if (!bus.ld_req || e_lda) begin
            bus.ld_req   = (int'($urandom_range(99)) < pct);
            bus.ld_we    = 1'($urandom);
            bus.ld_addr  = 14'($urandom);
            bus.ld_wdata = $urandom;
        end
        bus.mem_rdata = $urandom;
    endtask

    initial begin
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // Single fetch
        phase = 1; bus.if_req = 1'b1; bus.if_addr = 14'h0004; bus.mem_rdata = 32'h0000_0013;
        repeat (5) step();
        bus.if_req = 1'b0;
        repeat (2) step();

        // Loader write
        phase = 2; bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 14'h0010; bus.ld_wdata = 32'hDEAD_BEEF;
        repeat (5) step();
        bus.ld_req = 1'b0; bus.ld_we = 1'b0;
        repeat (2) step();

        // Flush during a fetch, then the redirected fetch
        phase = 3; bus.mem_rdata = 32'hCAFE_0020; bus.if_req = 1'b1; bus.if_addr = 14'h0008;
        repeat (2) step();
        bus.if_flush = 1'b1; bus.if_addr = 14'h0020;
        step();
        bus.if_flush = 1'b0;
        repeat (6) step();
        bus.if_req = 1'b0;
        repeat (2) step();

        // Reset in the middle of a loader read
        phase = 4; bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 14'h0030; bus.mem_rdata = 32'h1234_5678;
        repeat (2) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (5) step();
        bus.ld_req = 1'b0;
        repeat (2) step();

        // Both requesters held from reset
        phase = 5; rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 14'($urandom);
        bus.ld_req = 1'b1; bus.ld_we = 1'($urandom); bus.ld_addr = 14'($urandom); bus.ld_wdata = $urandom;
        step();
        rst = 1'b1;
        repeat (13) begin
            step();
            drive(100, 0);
        end

        // Random traffic with flushes and one reset pulse
        phase = 6;
        for (int i = 0; i < 700; i++) begin
            step();
            if (i == 350) rst = 1'b0;
            if (i == 352) rst = 1'b1;
            drive(55, 8);
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter WAIT_CYC, default 1, legal 1..15: cycles mem_cs is held per memory access.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 if_req  input  1  fetch request; held with if_addr stable until if_valid or if_flush.
REQ-005 if_addr  input  14  fetch word address.
REQ-006 if_flush  input  1  branch-taken flush; cancels any fetch in flight.
REQ-007 if_valid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 if_stall  output  1  fetch stall to the IF stage.
REQ-010 ld_req  input  1  loader request; held with ld_we/ld_addr/ld_wdata stable until ld_ack.
REQ-011 ld_we  input  1  1 = write, 0 = read.
REQ-012 ld_addr  input  14  loader word address.
REQ-013 ld_wdata  input  32  loader write data.
REQ-014 ld_ack  output  1  one-cycle completion pulse.
REQ-015 ld_rdata  output  32  loader read data, valid with ld_ack on reads.
REQ-016 mem_cs, mem_we  output  1 each  SRAM chip select and write enable.
REQ-017 mem_addr  output  14; mem_wdata  output  32  SRAM address and write data.
REQ-018 mem_rdata  input  32  SRAM read data, valid in the cycle after the mem_cs window.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ACC, RESP; arbitration occurs only in IDLE and RESP.
REQ-021 Arbitration: a single requester gets the grant; if both request, the one not granted last (last_gnt bit) wins; no request -> IDLE.
REQ-022 At grant the block latches owner, address, we, and wdata into registers, loads the wait counter with WAIT_CYC-1, and enters ACC next cycle.
REQ-023 In ACC, mem_cs=1 and mem_addr/mem_we/mem_wdata come from the latched registers; the counter decrements each cycle; at 0 go to RESP.
REQ-024 Outside ACC, mem_cs=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
REQ-025 RESP, fetch owner: if_valid=1 and if_rdata=mem_rdata, unless the drop flag is set.
REQ-026 RESP, loader owner: ld_ack=1; on reads, ld_rdata=mem_rdata; on writes, ld_rdata holds its previous value.
REQ-027 Access latency, grant cycle to response pulse: WAIT_CYC+1 cycles; maximum throughput is one access per WAIT_CYC+1 cycles.
REQ-028 if_stall = if_req AND NOT if_valid, combinational; forced 0 while if_flush=1.
REQ-029 if_flush during a fetch's ACC sets the drop flag; the access completes on the SRAM, and no if_valid is issued in RESP.
REQ-030 if_flush in RESP of a fetch suppresses that cycle's if_valid.
REQ-031 if_flush has no effect on a loader access.
REQ-032 A flushed fetch is not retried; the IF stage reissues if_req with the new address.
REQ-033 The drop flag clears on every new grant.
REQ-034 If if_req and if_flush are both 1 in an arbitration cycle, the fetch is not granted that cycle.
REQ-035 last_gnt updates at every grant; a requester waits at most one access for the other requester, so neither starves.

Reset
REQ-036 While rst=0: state=IDLE, counter=0, drop=0, last_gnt=loader (fetch wins the first tie).
REQ-037 While rst=0: all outputs and data registers are 0, including mem_cs, mem_we, if_valid, ld_ack, if_rdata, and ld_rdata.
REQ-038 Reset asserted mid-access aborts it immediately with no pulse; a requester still holding req after reset is re-arbitrated from IDLE.

Verification
REQ-039 WAIT_CYC=1, if_req only, if_addr=0x0004, mem_rdata=0x00000013 -> mem_cs high 1 cycle with mem_addr=0x0004; if_valid with 0x00000013 two cycles after grant; if_stall high until then.
REQ-040 WAIT_CYC=3, ld_req write, addr=0x0010, wdata=0xDEADBEEF -> mem_cs=mem_we=1 for exactly 3 cycles; ld_ack 4 cycles after grant; no if_valid.
REQ-041 if_req and ld_req both held from reset -> grants alternate fetch, loader, fetch, ...; each requester gets a pulse every second access.
REQ-042 if_flush pulsed in ACC of fetch 0x0008 -> no if_valid in RESP, if_stall=0 during flush; the new if_req 0x0020 is granted at the next arbitration and returns its data.
REQ-043 rst dropped while in ACC with WAIT_CYC=4 -> mem_cs=0 immediately and no ack; after release the held ld_req completes normally.
